// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// ----------------
// Bus-side initiator for the combinational alu. One operation is accepted per
// transaction, the alu is strobed with a one-hot control word for a per-op
// settle time, and the captured HI/LO result is returned as one or two
// response beats (LO first, then HI for mul/div).
//
// Handshakes: a transfer on either the req_* or rsp_* channel happens on a
// rising clock edge where valid and ready are both 1. A producer holds valid
// and its payload stable until that edge; ready never depends on valid.
//
// Ports:
//   clock      rising-edge clock
//   clear      asynchronous active-low reset
//   req_valid  request present
//   req_ready  sequencer idle and able to accept a request
//   req_op     op index 0..11; 12..15 are illegal
//   req_a      operand X
//   req_b      operand Y
//   alu_ctrl   one-hot control to the alu (1 << op while the op settles)
//   alu_x      registered X to the alu
//   alu_y      registered Y to the alu
//   alu_hi     alu result high word
//   alu_lo     alu result low word
//   rsp_valid  response beat present
//   rsp_ready  consumer accepts beat
//   rsp_data   response word
//   rsp_last   final beat of the transaction
//   rsp_err    illegal op or divide-by-zero
//   state_dbg  current FSM state (0 idle, 1 wait, 2 send_lo, 3 send_hi)

module alu_op_sequencer #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 8,
  parameter int ALU_LAT   = 1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [BITS-1:0]      req_a,
  input  logic [BITS-1:0]      req_b,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [BITS-1:0]      alu_hi,
  input  logic [BITS-1:0]      alu_lo,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_data,
  output logic                 rsp_last,
  output logic                 rsp_err,
  output logic [1:0]           state_dbg
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ?
                           ((MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT) :
                           ((DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] NUM_OPS = 4'(SIG_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_SEND_LO = 2'd2,
    S_SEND_HI = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt;
  // rsp_data doubles as the captured ZLO while in S_SEND_LO; only ZHI needs
  // its own holding register for the second beat.
  logic [BITS-1:0]  zhi;

  // Gated by clear so the port reads 0 while reset is held and 1 as soon as
  // it is released, without waiting for a clock edge.
  assign req_ready = (state == S_IDLE) && clear;
  assign state_dbg = state;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      op_q      <= '0;
      cnt       <= '0;
      zhi       <= '0;
      alu_ctrl  <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            alu_x <= req_a;
            alu_y <= req_b;
            if ((req_op >= NUM_OPS) || (req_op == OP_DIV && req_b == '0)) begin
              // Rejected without ever strobing the alu: one zero beat, err set.
              zhi       <= '0;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_last  <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= S_SEND_LO;
            end else begin
              alu_ctrl <= SIG_COUNT'(1) << req_op;
              if (req_op == OP_MUL)      cnt <= CNT_W'(MUL_LAT - 1);
              else if (req_op == OP_DIV) cnt <= CNT_W'(DIV_LAT - 1);
              else                       cnt <= CNT_W'(ALU_LAT - 1);
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (cnt == '0) begin
            // Capture edge: alu_ctrl has been held for exactly LAT cycles.
            zhi       <= alu_hi;
            rsp_data  <= alu_lo;
            alu_ctrl  <= '0;
            rsp_valid <= 1'b1;
            rsp_last  <= !(op_q == OP_MUL || op_q == OP_DIV);
            rsp_err   <= 1'b0;
            state     <= S_SEND_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_SEND_LO: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
              rsp_err   <= 1'b0;
              state     <= S_IDLE;
            end else begin
              rsp_data <= zhi;
              rsp_last <= 1'b1;
              state    <= S_SEND_HI;
            end
          end
        end

        S_SEND_HI: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
